// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multi-cycle MIPS main controller with fetch/data handshakes,
// retired-instruction counter and bus-timeout watchdog.
// Ports: clk/reset_n (async active-low); instruction = IR contents;
// imem_ready/dmem_ready = memory handshakes; datapath strobes imem_req, ir_write,
// dmem_req, dmem_we, pc_write, reg_write, reg_dst, mem_to_reg, alu_src, alu_op,
// branch, jal, jr; illegal/bus_error one-cycle pulses; retired count; state debug.
module mips_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        branch,
  output logic        jal,
  output logic        jr,
  output logic        illegal,
  output logic        bus_error,
  output logic [31:0] retired,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, WB_R = 4'd3, EXEC_I = 4'd4,
    WB_I = 4'd5, MEM_ADDR = 4'd6, MEM_ACCESS = 4'd7, WB_MEM = 4'd8,
    BRANCH = 4'd9, JUMP = 4'd10, ILLEGAL = 4'd11, BUS_ERR = 4'd12
  } state_t;
  state_t cur, nxt;
  logic [7:0] wcnt;
  logic [5:0] op, funct;
  logic is_r, is_jr, is_jal, is_sw, tmo, unused_bits;
  assign op          = instruction[31:26];
  assign funct       = instruction[5:0];
  assign unused_bits = ^instruction[25:6];
  assign is_r        = op == 6'b000000;
  assign is_jr       = is_r && funct == 6'b001000;
  assign is_jal      = op == 6'b000011;
  assign is_sw       = op == 6'b101011;
  assign tmo         = wcnt == 8'(TIMEOUT - 1);
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:      nxt = imem_ready ? DECODE : tmo ? BUS_ERR : FETCH;
      DECODE:     nxt = is_jr ? JUMP : is_r ? EXEC_R : op == 6'b001000 ? EXEC_I :
                        (op == 6'b100011 || is_sw) ? MEM_ADDR : op == 6'b000100 ? BRANCH :
                        (op == 6'b000010 || is_jal) ? JUMP : ILLEGAL;
      EXEC_R:     nxt = WB_R;
      EXEC_I:     nxt = WB_I;
      MEM_ADDR:   nxt = MEM_ACCESS;
      MEM_ACCESS: nxt = dmem_ready ? (is_sw ? FETCH : WB_MEM) : tmo ? BUS_ERR : MEM_ACCESS;
      default:    nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= FETCH;
      wcnt    <= '0;
      retired <= '0;
    end else begin
      cur     <= nxt;
      // only the two wait states ever hold, so any transition restarts the count
      wcnt    <= (cur != nxt) ? 8'd0 : wcnt + 8'd1;
      retired <= pc_write ? retired + 32'd1 : retired;
    end
  end
  // every strobe is gated by reset_n so nothing is driven while reset is held
  assign imem_req   = reset_n && cur == FETCH;
  assign ir_write   = imem_req && imem_ready;
  assign dmem_req   = reset_n && cur == MEM_ACCESS;
  assign dmem_we    = dmem_req && is_sw;
  assign pc_write   = reset_n && (cur inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP, ILLEGAL} ||
                                  (cur == MEM_ACCESS && dmem_ready && is_sw));
  assign reg_write  = reset_n && (cur inside {WB_R, WB_I, WB_MEM} || (cur == JUMP && is_jal));
  assign reg_dst    = reset_n && cur == WB_R;
  assign mem_to_reg = reset_n && cur == WB_MEM;
  assign alu_src    = reset_n && cur inside {EXEC_I, WB_I, MEM_ADDR};
  assign alu_op     = !reset_n ? 2'b00 : cur == EXEC_R ? 2'b10 : cur == BRANCH ? 2'b01 : 2'b00;
  assign branch     = reset_n && cur == BRANCH;
  assign jal        = reset_n && cur == JUMP && is_jal;
  assign jr         = reset_n && cur == JUMP && is_jr;
  assign illegal    = reset_n && cur == ILLEGAL;
  assign bus_error  = reset_n && cur == BUS_ERR;
  assign state      = cur;
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: directed bench with a per-instruction expectation model.
module tb_mips_control_fsm;
  localparam int TO = 16;
  logic clk = 0, reset_n = 0, imem_ready = 0, dmem_ready = 0;
  logic [31:0] instruction = 0;
  logic imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write, reg_dst;
  logic mem_to_reg, alu_src, branch, jal, jr, illegal, bus_error;
  logic [1:0] alu_op;
  logic [31:0] retired;
  logic [3:0] state;
  mips_control_fsm #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .branch(branch), .jal(jal), .jr(jr), .illegal(illegal),
    .bus_error(bus_error), .retired(retired), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] st;
    logic imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write, reg_dst, mem_to_reg, alu_src;
    logic [1:0] alu_op;
    logic branch, jal, jr, illegal, bus_error;
    logic [31:0] ret;
  } exp_t;
  exp_t q[$];
  exp_t act, e_cmp;
  int compared = 0, mismatched = 0;
  logic [31:0] ret_m = 0;
  assign act = {state, imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write, reg_dst,
                mem_to_reg, alu_src, alu_op, branch, jal, jr, illegal, bus_error, retired};
  always @(negedge clk)
    if (q.size() > 0) begin
      e_cmp = q.pop_front();
      compared++;
      if (act !== e_cmp) begin
        mismatched++;
        $display("FAIL cycle t=%0t: got %h want %h", $time, act, e_cmp);
      end
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    compared++;
    if (a !== x) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, a, x);
    end
  endtask
  function automatic exp_t st(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction
  task automatic put(input exp_t e, input logic imr, input logic dmr);
    e.ret = ret_m;
    imem_ready = imr;
    dmem_ready = dmr;
    q.push_back(e);
    if (e.pc_write) ret_m++;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] ins, input int iw, input int dw, input bit abort,
                     output int rc, output int bc);
    logic [5:0] op, fn;
    exp_t e;
    int n, w;
    instruction = ins;
    op = ins[31:26];
    fn = ins[5:0];
    n = 0; w = 0; rc = 0; bc = 0;
    for (int i = 0; i < iw; i++) begin
      e = st(0); e.imem_req = 1; put(e, 0, 0); n++; w++;
      if (w == TO) begin
        e = st(12); e.bus_error = 1; put(e, 0, 0); n++; bc = n; w = 0;
      end
    end
    e = st(0); e.imem_req = 1; e.ir_write = 1; put(e, 1, 0); n++;
    e = st(1); put(e, 0, 0); n++;
    if (op == 6'h00 && fn != 6'h08) begin
      e = st(2); e.alu_op = 2'b10; put(e, 0, 0); n++;
      e = st(3); e.reg_write = 1; e.reg_dst = 1; e.pc_write = 1; put(e, 0, 0); n++; rc = n;
    end else if (op == 6'h08) begin
      e = st(4); e.alu_src = 1; put(e, 0, 0); n++;
      e = st(5); e.reg_write = 1; e.alu_src = 1; e.pc_write = 1; put(e, 0, 0); n++; rc = n;
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = st(6); e.alu_src = 1; put(e, 0, 0); n++;
      for (int i = 0; i < dw; i++) begin
        e = st(7); e.dmem_req = 1; e.dmem_we = (op == 6'h2B); put(e, 0, 0); n++;
      end
      if (abort) return;
      e = st(7); e.dmem_req = 1; e.dmem_we = (op == 6'h2B); e.pc_write = (op == 6'h2B);
      put(e, 0, 1); n++;
      if (op == 6'h2B) rc = n;
      else begin
        e = st(8); e.reg_write = 1; e.mem_to_reg = 1; e.pc_write = 1; put(e, 0, 0); n++; rc = n;
      end
    end else if (op == 6'h04) begin
      e = st(9); e.alu_op = 2'b01; e.branch = 1; e.pc_write = 1; put(e, 0, 0); n++; rc = n;
    end else if (op == 6'h00 || op == 6'h02 || op == 6'h03) begin
      e = st(10); e.pc_write = 1; e.jal = (op == 6'h03); e.reg_write = (op == 6'h03);
      e.jr = (op == 6'h00); put(e, 0, 0); n++; rc = n;
    end else begin
      e = st(11); e.illegal = 1; e.pc_write = 1; put(e, 0, 0); n++; rc = n;
    end
  endtask
  initial begin
    int rc, bc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write, bus_error}), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    reset_n = 1;
    run(32'h00221820, 0, 0, 0, rc, bc); chk("add_rc", rc, 4); chk("add_ret", retired, 1);
    run(32'h8C220004, 0, 3, 0, rc, bc); chk("lw_rc", rc, 8);
    run(32'hAC220004, 0, 0, 0, rc, bc); chk("sw_rc", rc, 4);
    run(32'h20220005, 0, 0, 0, rc, bc); chk("addi_rc", rc, 4);
    run(32'h10220003, 0, 0, 0, rc, bc); chk("beq_rc", rc, 3);
    run(32'h08000004, 0, 0, 0, rc, bc); chk("j_rc", rc, 3);
    chk("ret_before_jal", retired, 6);
    run(32'h0C000010, 0, 0, 0, rc, bc);
    run(32'h03E00008, 0, 0, 0, rc, bc); chk("jal_jr_ret", retired, 8);
    run(32'hFC000000, 0, 0, 0, rc, bc); chk("ill_rc", rc, 3); chk("ill_ret", retired, 9);
    run(32'h00221820, 16, 0, 0, rc, bc); chk("timeout_bc", bc, 17); chk("timeout_ret", retired, 10);
    run(32'h00221820, 15, 0, 0, rc, bc); chk("edge_bc", bc, 0); chk("edge_ret", retired, 11);
    run(32'h8C220004, 0, 2, 1, rc, bc);
    reset_n = 0;
    #1;
    chk("abort_strobes", 32'({imem_req, dmem_req, pc_write, reg_write, mem_to_reg}), 0);
    chk("abort_state", 32'(state), 0);
    chk("abort_retired", retired, 0);
    ret_m = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    run(32'h20220005, 0, 0, 0, rc, bc); chk("restart_ret", retired, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
